pipe_skid_buf: RTL and testbench
================================

PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter RST_VALUE, default 0, value loaded into data registers on reset.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, stall-counter width.
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_flush  input  1  synchronous pipeline flush, drops all held data.
REQ-007 SHALL have port i_valid  input  1  upstream data valid.
REQ-008 SHALL have port o_ready  output  1  upstream may transfer this cycle.
REQ-009 SHALL have port i_data  input  DATA_WIDTH  upstream payload.
REQ-010 SHALL have port o_valid  output  1  downstream data valid.
REQ-011 SHALL have port i_ready  input  1  downstream accepts this cycle.
REQ-012 SHALL have port o_data  output  DATA_WIDTH  downstream payload, driven from the main register.
REQ-013 SHALL have port o_stall_cnt  output  CNT_WIDTH  count of downstream stall cycles.

Function
REQ-014 SHALL count an upstream transfer when i_valid && o_ready and a downstream transfer when o_valid && i_ready, both at the rising edge.
REQ-015 SHALL implement three states: EMPTY (no entry), BUSY (main entry only), FULL (main plus skid entry).
REQ-016 SHALL drive o_valid = (state != EMPTY) and o_ready = (state != FULL); both outputs registered, with no combinational path from i_ready to o_ready.
REQ-017 In EMPTY, on i_valid, SHALL load main <= i_data and go to BUSY.
REQ-018 In BUSY with i_valid && i_ready, SHALL load main <= i_data and stay in BUSY.
REQ-019 In BUSY with i_valid && !i_ready, SHALL load skid <= i_data and go to FULL.
REQ-020 In BUSY with !i_valid && i_ready, SHALL go to EMPTY.
REQ-021 In BUSY with !i_valid && !i_ready, SHALL hold main unchanged.
REQ-022 In FULL with i_ready, SHALL load main <= skid and go to BUSY; upstream is not accepted in this cycle (o_ready = 0).
REQ-023 In FULL with !i_ready, SHALL hold both entries unchanged.
REQ-024 SHALL have a latency of 1 cycle from upstream transfer to o_valid when the block is empty.
REQ-025 SHALL deliver data in order, with no loss or duplication; sustained throughput SHALL be 1 transfer per cycle while i_ready = 1.
REQ-026 SHALL hold o_data stable while o_valid && !i_ready.
REQ-027 On i_flush, SHALL go to EMPTY on the next cycle regardless of state, discarding main, skid and any concurrent upstream transfer.
REQ-028 i_flush SHALL override all handshake events; i_rst SHALL override i_flush.
REQ-029 SHALL increment o_stall_cnt each cycle o_valid && !i_ready, saturating at 2^CNT_WIDTH-1 with no wrap.
REQ-030 i_flush SHALL NOT clear o_stall_cnt.

Reset
REQ-031 While i_rst = 1 at a clock edge, SHALL set state EMPTY, o_valid 0, o_ready 1, main and skid RST_VALUE, o_data RST_VALUE, and o_stall_cnt 0.
REQ-032 Reset asserted mid-operation SHALL discard all held entries; the first transfer after deassertion SHALL be accepted on the next edge.

Structure
REQ-033 SHALL define the state enum type (EMPTY, BUSY, FULL) in shared package pipe_pkg.
REQ-034 SHALL build main and skid storage from sub-module reg_sync_en (synchronous active-high reset, enable, RST_VALUE parameter), instantiated twice.

Verification
REQ-035 Reset: hold i_rst for 2 cycles -> o_valid 0, o_ready 1, o_data 0, o_stall_cnt 0.
REQ-036 Streaming: i_valid = 1 with data 1,2,3,4 on consecutive cycles, i_ready = 1 -> o_data 1,2,3,4 on consecutive cycles starting 1 cycle later, o_ready constantly 1.
REQ-037 Backpressure: send 0xA, 0xB while i_ready = 0 -> state FULL, o_ready 0, o_data 0xA; then raise i_ready -> 0xA then 0xB delivered, o_ready back to 1, o_stall_cnt equal to the number of stalled cycles.
REQ-038 Flush: in FULL, assert i_flush together with i_valid (data 0xC) -> next cycle o_valid 0 and o_ready 1; 0xA, 0xB and 0xC are never output.
REQ-039 Saturation: with CNT_WIDTH = 3, hold o_valid = 1 and i_ready = 0 for 10 cycles -> o_stall_cnt stops at 7.
REQ-040 Random: random i_valid/i_ready at 50% for 10,000 cycles with a scoreboard -> in-order, lossless delivery, and o_data stable whenever o_valid && !i_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_buf_if.sv
// Valid/ready stream bundle; the master drives valid/data and the slave drives ready.
interface pipe_skid_buf_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/reg_sync_en.sv
// Data register with enable and a synchronous active-high reset to a parameterised value.
module reg_sync_en #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RST_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= RST_VALUE;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: main register feeds o_data, skid absorbs one beat when downstream stalls.
// Handshake outputs come straight from flops so i_ready never reaches o_ready combinationally.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RST_VALUE  = '0,
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_stall_cnt
);

  pipe_state_e           state_q, state_d;
  logic                  valid_q, ready_q;
  logic                  main_en, skid_en;
  logic [DATA_WIDTH-1:0] main_d, main_q, skid_q;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= EMPTY;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= (state_d != EMPTY);
      ready_q     <= (state_d != FULL);
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Flush wins over every handshake event; the data registers keep stale contents,
  // which is harmless because valid drops with the state.
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = i_data;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (i_valid) begin
            main_en = 1'b1;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (i_valid && i_ready) begin
            main_en = 1'b1;
          end else if (i_valid) begin
            skid_en = 1'b1;
            state_d = FULL;
          end else if (i_ready) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (i_ready) begin
            main_en = 1'b1;
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_q && !i_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  reg_sync_en #(
    .WIDTH     (DATA_WIDTH),
    .RST_VALUE (RST_VALUE)
  ) u_main_reg (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  reg_sync_en #(
    .WIDTH     (DATA_WIDTH),
    .RST_VALUE (RST_VALUE)
  ) u_skid_reg (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .en_i  (skid_en),
    .d_i   (i_data),
    .q_o   (skid_q)
  );

  assign o_valid     = valid_q;
  assign o_ready     = ready_q;
  assign o_data      = main_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Scoreboard bench for pipe_skid_buf: directed streaming/backpressure/flush/reset/saturation, then random traffic.
module tb_pipe_skid_buf;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [15:0]   stallCnt;
  logic          satValid, satReady;
  logic [DW-1:0] satData;
  logic [2:0]    satStall;

  pipe_skid_buf_if #(.DATA_WIDTH(DW)) upIf ();
  pipe_skid_buf_if #(.DATA_WIDTH(DW)) dnIf ();

  logic [DW-1:0] expQ[$];
  int            compareCount   = 0;
  int            mismatchCount  = 0;
  int            deliveredCount = 0;
  int            stallModel     = 0;
  int            satModel       = 0;
  logic          heldValid      = 1'b0;
  logic [DW-1:0] heldData       = '0;

  always #5 clk = ~clk;

  pipe_skid_buf #(.DATA_WIDTH(DW), .RST_VALUE('0), .CNT_WIDTH(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_valid     (upIf.valid),
    .o_ready     (upIf.ready),
    .i_data      (upIf.data),
    .o_valid     (dnIf.valid),
    .i_ready     (dnIf.ready),
    .o_data      (dnIf.data),
    .o_stall_cnt (stallCnt)
  );

  // Narrow-counter twin sharing the same stimulus, used only for saturation.
  pipe_skid_buf #(.DATA_WIDTH(DW), .RST_VALUE('0), .CNT_WIDTH(3)) dutSat (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_valid     (upIf.valid),
    .o_ready     (satReady),
    .i_data      (upIf.data),
    .o_valid     (satValid),
    .i_ready     (dnIf.ready),
    .o_data      (satData),
    .o_stall_cnt (satStall)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at the falling edge; samples the handshake 1ns before the rising edge and returns at the next falling edge.
  task automatic cycle();
    #4;
    if (rst) begin
      expQ.delete();
      heldValid  = 1'b0;
      stallModel = 0;
      satModel   = 0;
    end else begin
      if (heldValid) begin
        checkOutput("hold_valid", 32'(dnIf.valid), 32'd1);
        checkOutput("hold_data", dnIf.data, heldData);
      end
      if (dnIf.valid && !dnIf.ready) begin
        if (stallModel < 65535) stallModel++;
        if (satModel < 7) satModel++;
      end
      if (flush) begin
        expQ.delete();
        heldValid = 1'b0;
      end else begin
        if (dnIf.valid && dnIf.ready) begin
          if (expQ.size() == 0) checkOutput("spurious_out", dnIf.data, 32'hDEAD_BEEF);
          else checkOutput("data_order", dnIf.data, expQ.pop_front());
          deliveredCount++;
        end
        if (upIf.valid && upIf.ready) expQ.push_back(upIf.data);
        heldValid = dnIf.valid && !dnIf.ready;
        heldData  = dnIf.data;
      end
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    upIf.valid = v;
    upIf.data  = d;
    dnIf.ready = r;
    flush      = f;
    cycle();
  endtask

  initial begin
    int startCount;
    logic rv, rr;
    logic [DW-1:0] rd;
    rst        = 1'b1;
    flush      = 1'b0;
    upIf.valid = 1'b0;
    upIf.data  = '0;
    dnIf.ready = 1'b0;
    @(negedge clk);

    // Reset held for two cycles.
    repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("rst_valid", 32'(dnIf.valid), 32'd0);
    checkOutput("rst_ready", 32'(upIf.ready), 32'd1);
    checkOutput("rst_data", dnIf.data, 32'd0);
    checkOutput("rst_stall", 32'(stallCnt), 32'd0);
    checkOutput("rst_sat_stall", 32'(satStall), 32'd0);

    // Streaming at full rate: each beat appears one cycle after it is sent.
    startCount = deliveredCount;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b1, 1'b0);
      checkOutput("stream_ready", 32'(upIf.ready), 32'd1);
      checkOutput("stream_valid", 32'(dnIf.valid), 32'd1);
      checkOutput("stream_data", dnIf.data, 32'(i));
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("stream_end_valid", 32'(dnIf.valid), 32'd0);
    checkOutput("stream_count", 32'(deliveredCount - startCount), 32'd4);

    // Backpressure fills the skid entry, then drains in order.
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
    checkOutput("bp_busy_data", dnIf.data, 32'hA);
    checkOutput("bp_busy_ready", 32'(upIf.ready), 32'd1);
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
    checkOutput("bp_full_ready", 32'(upIf.ready), 32'd0);
    checkOutput("bp_full_valid", 32'(dnIf.valid), 32'd1);
    checkOutput("bp_full_data", dnIf.data, 32'hA);
    checkOutput("bp_stall1", 32'(stallCnt), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("bp_hold_data", dnIf.data, 32'hA);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("bp_second_data", dnIf.data, 32'hB);
    checkOutput("bp_second_ready", 32'(upIf.ready), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("bp_drained_valid", 32'(dnIf.valid), 32'd0);
    checkOutput("bp_drained_ready", 32'(upIf.ready), 32'd1);
    checkOutput("bp_stall_cnt", 32'(stallCnt), 32'd2);

    // Flush in FULL together with an upstream beat discards everything.
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
    checkOutput("fl_full_ready", 32'(upIf.ready), 32'd0);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b1);
    checkOutput("fl_valid", 32'(dnIf.valid), 32'd0);
    checkOutput("fl_ready", 32'(upIf.ready), 32'd1);
    repeat (3) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("fl_no_output", 32'(dnIf.valid), 32'd0);
    end
    checkOutput("fl_stall_kept", 32'(stallCnt), 32'd4);

    // Saturation of the 3-bit counter over ten stalled cycles.
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 32'hD, 1'b0, 1'b0);
    repeat (10) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("sat_stall", 32'(satStall), 32'd7);
    checkOutput("wide_stall", 32'(stallCnt), 32'd10);
    checkOutput("sat_valid", 32'(satValid), 32'd1);
    checkOutput("sat_ready", 32'(satReady), 32'd1);
    checkOutput("sat_data", satData, 32'hD);

    // Reset in the middle of a full buffer, then an immediate new beat.
    applyStimulus(1'b1, 32'hE, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("mid_rst_valid", 32'(dnIf.valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(upIf.ready), 32'd1);
    checkOutput("mid_rst_data", dnIf.data, 32'd0);
    checkOutput("mid_rst_stall", 32'(stallCnt), 32'd0);
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b0);
    checkOutput("post_rst_valid", 32'(dnIf.valid), 32'd1);
    checkOutput("post_rst_data", dnIf.data, 32'h55);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Random traffic at 50% valid / 50% ready.
    for (int n = 0; n < 10000; n++) begin
      rv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rd = DW'($urandom);
      applyStimulus(rv, rd, rr, 1'b0);
    end
    upIf.valid = 1'b0;
    dnIf.ready = 1'b1;
    for (int k = 0; k < 8 && expQ.size() > 0; k++) cycle();
    checkOutput("rand_drained", 32'(expQ.size()), 32'd0);
    checkOutput("rand_stall", 32'(stallCnt), 32'(stallModel));
    checkOutput("rand_sat_stall", 32'(satStall), 32'(satModel));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
